// File: rtl/wrd_pkg.sv
// Shared helpers for the word (wrd) datapath: width derivation and
// narrowing of full-precision sums to the output element width.
package wrd_pkg;

  // Widest sum the narrowing helper can handle; O_BW and SUM_BW must not exceed it.
  localparam int NARROW_BW = 64;

  // Ceiling log2 for elaboration-time width math (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width at which NUM_IN signed I_BW-bit values can be summed without overflow.
  function automatic int sum_bw(input int i_bw, input int num_in);
    return i_bw + clog2(num_in);
  endfunction

  // Narrow a sign-extended sum to o_bw bits. The caller keeps the low o_bw
  // bits of the result, so returning the value unchanged means either a
  // sign-extension (o_bw >= s_bw) or a two's-complement wrap (no saturate).
  function automatic logic signed [NARROW_BW-1:0] sat_narrow(
    input logic signed [NARROW_BW-1:0] val,
    input int                          o_bw,
    input int                          s_bw,
    input bit                          saturate
  );
    logic signed [NARROW_BW-1:0] hi;
    logic signed [NARROW_BW-1:0] lo;
    hi = (64'sd1 <<< (o_bw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if ((o_bw >= s_bw) || !saturate) return val;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/vec_add_skid.sv
// Two-entry output stage: a main register driving the outputs plus one skid
// entry that absorbs the beat already in flight when downstream stalls.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. Upstream valid must not depend on in_ready_o;
// in_ready_o is a register (skid entry empty), so there is no combinational
// path from out_ready_i back to in_ready_o. Out data is stable while
// out_valid_o is high and out_ready_i is low.
module vec_add_skid #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  logic [PAYLOAD_W-1:0] main_data_q, main_data_d;
  logic                 main_valid_q, main_valid_d;
  logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 ready_q, ready_d;
  logic                 accept;
  logic                 pop;

  assign accept = in_valid_i & ready_q;
  assign pop    = main_valid_q & out_ready_i;

  // Next-state for both entries; a full skid always refills main before new input.
  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_data_d = in_data_i;
      end
    end else if (accept) begin
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  // State registers; reset drops every held beat and deasserts ready.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_data_o  = main_data_q;
  assign out_valid_o = main_valid_q;

endmodule

// File: rtl/vec_add_n.sv
// N-channel signed element-wise vector adder. Joins NUM_IN streams, sums at
// full precision, narrows each element to O_BW and hands the result to a
// two-entry skid output stage.
module vec_add_n
  import wrd_pkg::*;
#(
  parameter int NUM_IN     = 3,
  parameter int I_BW       = 16,
  parameter int O_BW       = 18,
  parameter int VECTOR_LEN = 13,
  parameter int SATURATE   = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [NUM_IN*VECTOR_LEN*I_BW-1:0] data_i,
  input  logic [NUM_IN-1:0]                valid_i,
  input  logic [NUM_IN-1:0]                last_i,
  output logic [NUM_IN-1:0]                ready_o,
  output logic [VECTOR_LEN*O_BW-1:0]       data_o,
  output logic                             valid_o,
  output logic                             last_o,
  input  logic                             ready_i,
  output logic                             last_err_o
);

  localparam int SUM_BW    = sum_bw(I_BW, NUM_IN);
  localparam int DATA_W    = VECTOR_LEN * O_BW;
  localparam int PAYLOAD_W = DATA_W + 1;

  logic signed [SUM_BW-1:0] sum_v [VECTOR_LEN];
  logic [DATA_W-1:0]        narrow_flat;
  logic [PAYLOAD_W-1:0]     out_payload;
  logic                     all_valid;
  logic                     stage_ready;
  logic                     accept;
  logic                     last_mixed;
  logic                     last_err_q;

  assign all_valid  = &valid_i;
  assign accept     = all_valid & stage_ready;
  // Frame markers disagree across channels: neither all-low nor all-high.
  assign last_mixed = (|last_i) & ~(&last_i);

  // Element-wise sum, each channel sign-extended to SUM_BW so it cannot overflow.
  always_comb begin
    for (int e = 0; e < VECTOR_LEN; e++) begin
      sum_v[e] = '0;
      for (int k = 0; k < NUM_IN; k++) begin
        sum_v[e] = sum_v[e]
                 + SUM_BW'($signed(data_i[(k*VECTOR_LEN + e)*I_BW +: I_BW]));
      end
    end
  end

  // Narrow each sum to O_BW (extend, clamp or wrap depending on widths and SATURATE).
  always_comb begin
    narrow_flat = '0;
    for (int e = 0; e < VECTOR_LEN; e++) begin
      narrow_flat[e*O_BW +: O_BW] =
        O_BW'(sat_narrow(NARROW_BW'(sum_v[e]), O_BW, SUM_BW, SATURATE != 0));
    end
  end

  vec_add_skid #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .in_data_i  ({|last_i, narrow_flat}),
    .in_valid_i (all_valid),
    .in_ready_o (stage_ready),
    .out_data_o (out_payload),
    .out_valid_o(valid_o),
    .out_ready_i(ready_i)
  );

  // Sticky flag for a joined beat whose channels disagreed on end-of-frame.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_err_q <= 1'b0;
    end else if (accept && last_mixed) begin
      last_err_q <= 1'b1;
    end
  end

  assign ready_o    = {NUM_IN{stage_ready}};
  assign data_o     = out_payload[DATA_W-1:0];
  assign last_o     = out_payload[PAYLOAD_W-1];
  assign last_err_o = last_err_q;

endmodule

// File: tb/tb_vec_add_n.sv
// Bench for vec_add_n: one default instance (O_BW=18, saturating) plus two
// 16-bit output instances (saturate / wrap) sharing the same stimulus.
module tb_vec_add_n;

  localparam int NUM_IN = 3;
  localparam int I_BW   = 16;
  localparam int VL     = 13;
  localparam int SB     = 18;
  localparam int CH_W   = VL * I_BW;
  localparam int EXP_W  = VL * SB + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst_n;
  logic [NUM_IN*CH_W-1:0]      data_i;
  logic [NUM_IN-1:0]           valid_i;
  logic [NUM_IN-1:0]           last_i;
  logic                        ready_i;

  logic [NUM_IN-1:0]           ready_o, ready_s, ready_w;
  logic [VL*18-1:0]            data_o;
  logic [VL*16-1:0]            data_s, data_w;
  logic                        valid_o, valid_s, valid_w;
  logic                        last_o, last_s, last_w;
  logic                        err_o, err_s, err_w;

  vec_add_n #(.NUM_IN(3), .I_BW(16), .O_BW(18), .VECTOR_LEN(13), .SATURATE(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
    .ready_i(ready_i), .last_err_o(err_o));

  vec_add_n #(.NUM_IN(3), .I_BW(16), .O_BW(16), .VECTOR_LEN(13), .SATURATE(1)) dut_s16 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_s), .data_o(data_s), .valid_o(valid_s), .last_o(last_s),
    .ready_i(ready_i), .last_err_o(err_s));

  vec_add_n #(.NUM_IN(3), .I_BW(16), .O_BW(16), .VECTOR_LEN(13), .SATURATE(0)) dut_w16 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
    .ready_o(ready_w), .data_o(data_w), .valid_o(valid_w), .last_o(last_w),
    .ready_i(ready_i), .last_err_o(err_w));

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- scoreboard ----------------
  // Entry: {OR of last_i, 13 x 18-bit full-precision sums}.
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_push, mon_exp;
  logic [VL*18-1:0] e18;
  logic [VL*16-1:0] es16, ew16;

  function automatic int clamp16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // Pop/compare on every output handshake, then push on every input join.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output: got data_o=%h with no beat expected", data_o);
        end else begin
          mon_exp = exp_q.pop_front();
          for (int e = 0; e < VL; e++) begin
            int s;
            s = int'($signed(mon_exp[e*SB +: SB]));
            e18[e*18 +: 18]  = mon_exp[e*SB +: SB];
            es16[e*16 +: 16] = 16'(clamp16(s));
            ew16[e*16 +: 16] = 16'(s);
          end
          total_cnt++;
          if ({last_o, data_o} !== {mon_exp[EXP_W-1], e18})
            $display("FAIL out_o18: got last=%b data=%h, expected last=%b data=%h",
                     last_o, data_o, mon_exp[EXP_W-1], e18);
          else pass_cnt++;
          total_cnt++;
          if ({valid_s, last_s, data_s} !== {1'b1, mon_exp[EXP_W-1], es16})
            $display("FAIL out_sat16: got v=%b last=%b data=%h, expected v=1 last=%b data=%h",
                     valid_s, last_s, data_s, mon_exp[EXP_W-1], es16);
          else pass_cnt++;
          total_cnt++;
          if ({valid_w, last_w, data_w} !== {1'b1, mon_exp[EXP_W-1], ew16})
            $display("FAIL out_wrap16: got v=%b last=%b data=%h, expected v=1 last=%b data=%h",
                     valid_w, last_w, data_w, mon_exp[EXP_W-1], ew16);
          else pass_cnt++;
        end
      end
      if ((&valid_i) && ready_o[0]) begin
        for (int e = 0; e < VL; e++) begin
          int s;
          s = 0;
          for (int k = 0; k < NUM_IN; k++) s += int'($signed(data_i[k*CH_W + e*I_BW +: I_BW]));
          mon_push[e*SB +: SB] = 18'(s);
        end
        mon_push[EXP_W-1] = |last_i;
        exp_q.push_back(mon_push);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rand();
    for (int k = 0; k < NUM_IN; k++)
      for (int e = 0; e < VL; e++)
        data_i[k*CH_W + e*I_BW +: I_BW] = 16'($urandom_range(0, 65535));
  endtask

  task automatic set_e0(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    data_i[0 +: 16]      = a;
    data_i[CH_W +: 16]   = b;
    data_i[2*CH_W +: 16] = c;
  endtask

  // Hold a joined beat until it is accepted; returns #1 after the accepting edge.
  task automatic send_beat(input logic [2:0] lst);
    logic acc;
    logic ok;
    ok      = 1'b0;
    valid_i = 3'b111;
    last_i  = lst;
    for (int n = 0; n < 50; n++) begin
      acc = ready_o[0];
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    valid_i = '0;
    last_i  = '0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL send_timeout: got no accept in 50 cycles, expected accept");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; valid_i = '0; last_i = '0; ready_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({valid_o, last_o, err_o} !== 3'b000)
      $display("FAIL reset_flags: got valid/last/err=%b%b%b, expected 000", valid_o, last_o, err_o);
    else pass_cnt++;
    total_cnt++;
    if (data_o !== '0) $display("FAIL reset_data: got %h, expected 0", data_o);
    else pass_cnt++;
    total_cnt++;
    if ({ready_o, ready_s} !== 6'b0) $display("FAIL reset_ready: got %b/%b, expected 000", ready_o, ready_s);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (ready_o !== 3'b111) $display("FAIL ready_after_reset: got %b, expected 111", ready_o);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    set_rand();
    set_e0(16'd100, 16'hFFE2, 16'd7);
    send_beat(3'b000);
    total_cnt++;
    if (valid_o !== 1'b1 || data_o[17:0] !== 18'd77)
      $display("FAIL basic_sum: got valid=%b e0=%h, expected valid=1 e0=%h", valid_o, data_o[17:0], 18'd77);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (valid_o !== 1'b0) $display("FAIL basic_pulse: got valid=%b, expected 0", valid_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_rand();
      send_beat(3'b000);
      total_cnt++;
      if (valid_o !== 1'b1 || ready_o !== 3'b111)
        $display("FAIL b2b_beat%0d: got valid=%b ready=%b, expected 1/111", i, valid_o, ready_o);
      else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    ready_i = 1'b1;
    set_rand();
    set_e0(16'h7FFF, 16'h7FFF, 16'h7FFF);
    send_beat(3'b000);
    total_cnt++;
    if ({data_o[17:0], data_s[15:0], data_w[15:0]} !== {18'd98301, 16'h7FFF, 16'h7FFD})
      $display("FAIL sat_pos: got o18=%h s16=%h w16=%h, expected 17ffd 7fff 7ffd",
               data_o[17:0], data_s[15:0], data_w[15:0]);
    else pass_cnt++;
    set_rand();
    set_e0(16'h8000, 16'h8000, 16'h8000);
    send_beat(3'b000);
    total_cnt++;
    if ({data_o[17:0], data_s[15:0], data_w[15:0]} !== {18'h28000, 16'h8000, 16'h8000})
      $display("FAIL sat_neg: got o18=%h s16=%h w16=%h, expected 28000 8000 8000",
               data_o[17:0], data_s[15:0], data_w[15:0]);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [VL*18-1:0] snap;
    ready_i = 1'b0;
    set_rand(); set_e0(16'd1, 16'd2, 16'd3);
    send_beat(3'b000);
    set_rand(); set_e0(16'd4, 16'd5, 16'd6);
    send_beat(3'b000);
    set_rand(); set_e0(16'd7, 16'd8, 16'd9);
    valid_i = 3'b111;
    snap = data_o;
    total_cnt++;
    if (ready_o !== 3'b000 || valid_o !== 1'b1 || data_o[17:0] !== 18'd6)
      $display("FAIL bp_full: got ready=%b valid=%b e0=%h, expected 000 1 6", ready_o, valid_o, data_o[17:0]);
    else pass_cnt++;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (data_o !== snap || valid_o !== 1'b1 || ready_o !== 3'b000)
      $display("FAIL bp_stable: got data=%h valid=%b ready=%b, expected data=%h 1 000",
               data_o, valid_o, ready_o, snap);
    else pass_cnt++;
    ready_i = 1'b1;
    send_beat(3'b000);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_join();
    int beats;
    ready_i = 1'b1;
    set_rand();
    valid_i = 3'b011;
    repeat (4) begin
      @(posedge clk); #1;
      total_cnt++;
      if (valid_o !== 1'b0 || ready_o !== 3'b111)
        $display("FAIL join_hold: got valid=%b ready=%b, expected 0 111", valid_o, ready_o);
      else pass_cnt++;
    end
    valid_i = 3'b111;
    @(posedge clk); #1;
    valid_i = '0;
    beats = 0;
    repeat (4) begin
      if (valid_o) beats++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (beats != 1) $display("FAIL join_count: got %0d beats, expected 1", beats);
    else pass_cnt++;
  endtask

  task automatic test_last();
    ready_i = 1'b1;
    total_cnt++;
    if (err_o !== 1'b0) $display("FAIL err_initial: got %b, expected 0", err_o);
    else pass_cnt++;
    set_rand();
    send_beat(3'b010);
    total_cnt++;
    if (last_o !== 1'b1 || err_o !== 1'b1)
      $display("FAIL last_mixed: got last=%b err=%b, expected 1 1", last_o, err_o);
    else pass_cnt++;
    set_rand();
    send_beat(3'b000);
    @(posedge clk); #1;
    total_cnt++;
    if ({err_o, err_s, err_w} !== 3'b111)
      $display("FAIL err_sticky: got %b%b%b, expected 111", err_o, err_s, err_w);
    else pass_cnt++;
    // Fill both entries, then reset in the middle of the stream.
    ready_i = 1'b0;
    set_rand(); send_beat(3'b000);
    set_rand(); send_beat(3'b111);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({valid_o, err_o, ready_o} !== 5'b00000)
      $display("FAIL mid_reset: got valid=%b err=%b ready=%b, expected 0 0 000", valid_o, err_o, ready_o);
    else pass_cnt++;
    rst_n   = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (valid_o !== 1'b0) $display("FAIL discard: got valid=%b after reset, expected 0", valid_o);
    else pass_cnt++;
    set_rand();
    send_beat(3'b111);
    total_cnt++;
    if (last_o !== 1'b1 || err_o !== 1'b0)
      $display("FAIL post_reset_beat: got last=%b err=%b, expected 1 0", last_o, err_o);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturate();
    test_backpressure();
    test_join();
    test_last();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d beats still expected, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vec_add_n.md
Name: vec_add_n

Overview:
- Parametrised N-channel signed vector adder for the word (wrd) datapath. Generalises the fixed 3-input adder.
- Joins NUM_IN valid/ready streams and adds them element-wise at full internal precision.
- Narrows each sum to O_BW by saturating or wrapping.
- Emits the result through a registered output stage with a skid buffer, so backpressure is honoured and no beat is lost or duplicated.

Parameters:
NUM_IN, 3, number of input streams (>=2)
I_BW, 16, signed element width per input
O_BW, 18, signed element width of output
VECTOR_LEN, 13, elements per vector
SATURATE, 1, 1 = clamp to O_BW signed range; 0 = two's-complement wrap (truncate)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_n_i  in  1  reset, synchronous, active-low
data_i  in  NUM_IN*VECTOR_LEN*I_BW  packed inputs; channel k at [k*VECTOR_LEN*I_BW +: VECTOR_LEN*I_BW]; element i of channel k at offset i*I_BW within it
valid_i  in  NUM_IN  per-channel valid
last_i  in  NUM_IN  per-channel end-of-frame
ready_o  out  NUM_IN  per-channel ready (all bits identical)
data_o  out  VECTOR_LEN*O_BW  packed sums; element i at [i*O_BW +: O_BW]
valid_o  out  1  output valid
last_o  out  1  output end-of-frame
ready_i  in  1  downstream ready
last_err_o  out  1  sticky: a beat was accepted with last_i not all-equal

Behaviour:
- Reset: when rst_n_i=0 at a clock edge, these are cleared:
  - valid_o=0, last_o=0, data_o=0, last_err_o=0.
  - Both skid entries are emptied.
  - ready_o=0 during reset; ready_o=all-ones on the first cycle after reset is released.
  - Reset mid-transfer discards any held beats.
- Internal width: SUM_BW = I_BW + clog2(NUM_IN). Every element is sign-extended to SUM_BW before adding, so the sum never overflows internally.
- Narrowing from SUM_BW to O_BW:
  - If O_BW >= SUM_BW: sign-extend.
  - Else, SATURATE=1: clamp to [-2^(O_BW-1), 2^(O_BW-1)-1].
  - Else, SATURATE=0: keep the low O_BW bits.
- Accept (join): accept = (&valid_i) & ready_o. A beat is consumed from all channels on the same cycle or from none. A channel showing valid while others are idle is held, not consumed.
- ready_o is registered: it equals "skid entry empty", so there is no combinational path from ready_i to ready_o.
- Pipeline:
  - Stage 1 is the output register (main); stage 2 is the skid entry.
  - Latency is 1 cycle from accept to valid_o.
  - With ready_i held high, throughput is 1 beat/cycle.
- Skid rules:
  - Accept while main is full and ready_i=0 → beat goes to skid and ready_o drops next cycle.
  - valid_o && ready_i with skid full → skid moves to main and ready_o rises next cycle.
  - Main empty or draining → the accepted beat loads main directly.
- Output stability: while valid_o=1 and ready_i=0, data_o and last_o stay stable.
- last handling:
  - last_o = OR of last_i captured at accept.
  - If last_i is neither all-0 nor all-1 at accept, last_err_o sets and holds until reset.
- Simultaneous events: on the same cycle as output pop plus a new accept, both occur. Occupancy never exceeds 2, and no beat is dropped or reordered.

Decomposition:
- Package wrd_pkg: clog2 function, SUM_BW derivation, and sat_narrow function (SUM_BW → O_BW with SATURATE select).
- Sub-module vec_add_skid: generic 2-entry skid buffer parametrised on payload width (VECTOR_LEN*O_BW+1). It owns the valid/ready/occupancy logic.
- Top level holds the unpack, sign-extend, adder tree, narrowing and last_err_o logic only.

Test Plan:
- NUM_IN=3, ready_i=1, all valid. Element0 inputs 100, -30, 7 → data_o element0 = 77 one cycle after accept; valid_o pulses once per accepted beat.
- SATURATE=1, I_BW=16, O_BW=16, three inputs of 32767 → element = 32767; three of -32768 → -32768.
- SATURATE=0, same stimulus → element = 32765 (low 16 bits of 98301) and -32768 (low 16 bits of -98304).
- Backpressure:
  - Hold ready_i=0 while streaming 3 beats → 2 accepted, ready_o=0 afterwards.
  - data_o stable across the stall.
  - Release ready_i → all beats emerge in order, none lost or duplicated.
- Join: valid_i=3'b011 for 4 cycles, then 3'b111 → no accept until all valid, exactly one output beat.
- last_i=3'b010 on an accepted beat → last_o=1 on that output beat and last_err_o=1 sticky. Assert rst_n_i=0 for one cycle mid-stream → valid_o=0, last_err_o=0, prior beats discarded.
